// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole pattern generator and its LFSR.
package mole_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSED} state_e;

   localparam logic [15:0] DEFAULT_TAPS = 16'h002D;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mole_pattern_gen_if.sv
// Game-FSM side controls and hole-driver side flags of the mole pattern generator.
interface mole_pattern_gen_if #(
   parameter int NUM_HOLES = 8
);
   logic                 start;
   logic                 stop;
   logic                 pause;
   logic                 speed;
   logic [NUM_HOLES-1:0] hit;
   logic [NUM_HOLES-1:0] ctrl;
   logic                 running;
   logic                 tick;

   modport master (output start, stop, pause, speed, hit,
                   input  ctrl, running, tick);

   modport slave  (input  start, stop, pause, speed, hit,
                   output ctrl, running, tick);
endinterface

// File: rtl/mole_lfsr.sv
// Shift-right LFSR with a zero-guarded seed load and a step enable.
module mole_lfsr
   import mole_pkg::*;
#(
   parameter int           W    = 16,
   parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] seed_i,
   input  logic         step_i,
   output logic [W-1:0] lfsr_o
);

   logic [W-1:0] lfsr_q, lfsr_d;

   always_comb begin
      // NOTE: default first, so the hold path is explicit and no latch is inferred.
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = (seed_i == '0) ? W'(1) : seed_i;
      end else if (step_i) begin
         lfsr_d = {^(lfsr_q & TAPS), lfsr_q[W-1:1]};
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= '0;
      else     lfsr_q <= lfsr_d;
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_pattern_gen.sv
// Mole pattern generator: LFSR-driven spawning on NUM_HOLES holes with
// per-hole lifetimes, a cap on lit holes and player hit clearing.
module mole_pattern_gen
   import mole_pkg::*;
#(
   parameter int                NUM_HOLES = 8,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS),
   parameter int                DIV_SLOW  = 50000000,
   parameter int                DIV_FAST  = 25000000,
   parameter int                MOLE_LIFE = 3,
   parameter int                MAX_UP    = 2
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   mole_pattern_gen_if.slave bus
);

   localparam int IDX_W  = clog2(NUM_HOLES);
   localparam int LIFE_W = clog2(MOLE_LIFE + 1);
   localparam int DIV_W  = clog2(DIV_SLOW);
   localparam int PC_W   = clog2(NUM_HOLES + 1);

   localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(MOLE_LIFE);
   localparam logic [DIV_W-1:0]  LAST_SLOW = DIV_W'(DIV_SLOW - 1);
   localparam logic [DIV_W-1:0]  LAST_FAST = DIV_W'(DIV_FAST - 1);
   localparam logic [PC_W-1:0]   MAX_UP_C  = PC_W'(MAX_UP);

   state_e                state_q, state_d;
   logic [LFSR_W-1:0]     seed_q;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [NUM_HOLES-1:0]  ctrl_q, ctrl_d;
   logic [LIFE_W-1:0]     life_q [NUM_HOLES];
   logic [LIFE_W-1:0]     life_d [NUM_HOLES];
   logic [LFSR_W-1:0]     lfsr;
   logic                  lfsr_load, lfsr_step;
   logic [DIV_W-1:0]      div_last;
   logic                  tick;
   logic [PC_W-1:0]       popcnt;
   logic [IDX_W-1:0]      spawn_idx;
   logic                  want;

   // The seed is captured on the IDLE->LOAD edge, so LOAD already holds the seeded value.
   mole_lfsr #(.W(LFSR_W), .TAPS(TAPS)) u_lfsr (
      .clk    (CLOCK_50),
      .rst    (reset),
      .load_i (lfsr_load),
      .seed_i (seed_q),
      .step_i (lfsr_step),
      .lfsr_o (lfsr)
   );

   assign div_last  = bus.speed ? LAST_FAST : LAST_SLOW;
   assign tick      = (state_q == RUN) && (div_q >= div_last);
   assign spawn_idx = lfsr[IDX_W-1:0];
   assign want      = lfsr[LFSR_W-1];

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < NUM_HOLES; i++) popcnt = popcnt + PC_W'(ctrl_q[i]);
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      ctrl_d    = ctrl_q;
      life_d    = life_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (!bus.stop && !bus.pause && bus.start) begin
               state_d   = LOAD;
               lfsr_load = 1'b1;
            end
         end
         LOAD: begin
            div_d   = '0;
            state_d = bus.stop ? IDLE : RUN;
         end
         RUN: begin
            div_d     = tick ? '0 : div_q + 1'b1;
            lfsr_step = tick;
            for (int i = 0; i < NUM_HOLES; i++) begin
               if (ctrl_q[i] && bus.hit[i]) begin
                  ctrl_d[i] = 1'b0;
                  life_d[i] = '0;
               end else if (ctrl_q[i] && tick) begin
                  life_d[i] = life_q[i] - 1'b1;
                  if (life_q[i] == LIFE_W'(1)) ctrl_d[i] = 1'b0;
               end
            end
            // Spawn check looks at pre-edge ctrl, so a hole expiring now still counts.
            if (tick && want && !ctrl_q[spawn_idx] && !bus.hit[spawn_idx] &&
                popcnt < MAX_UP_C) begin
               ctrl_d[spawn_idx] = 1'b1;
               life_d[spawn_idx] = LIFE_INIT;
            end
            if (bus.stop)       state_d = IDLE;
            else if (bus.pause) state_d = PAUSED;
         end
         PAUSED: begin
            if (bus.stop)        state_d = IDLE;
            else if (!bus.pause) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) begin
         ctrl_d = '0;
         for (int i = 0; i < NUM_HOLES; i++) life_d[i] = '0;
      end
   end

   // NOTE: the life array is a handful of flops, so it takes the async reset like all other state.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         seed_q  <= '0;
         div_q   <= '0;
         ctrl_q  <= '0;
         for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= '0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_q + 1'b1;
         div_q   <= div_d;
         ctrl_q  <= ctrl_d;
         life_q  <= life_d;
      end
   end

   assign bus.ctrl    = ctrl_q;
   assign bus.running = (state_q == RUN);
   assign bus.tick    = tick;

endmodule

// File: doc/mole_pattern_gen.md
Name: mole_pattern_gen

Overview:
- Parametrised successor to the single-bit random mole sequencer.
- Seeds an LFSR from a free-running counter when the user presses start, then advances the LFSR once per game tick.
- Spawns moles on NUM_HOLES outputs, each with a bounded lifetime, a cap on simultaneous moles, and player hit clearing.
- Sits between the game FSM (start/stop/pause/speed/hit) and the hole LED/display drivers (ctrl).

Parameters:
- NUM_HOLES, 8, number of hole channels; must be a power of two, 2..16.
- LFSR_W, 16, LFSR and seed-counter width; must be >= 4.
- TAPS, 16'h002D, feedback mask; fb = XOR of lfsr bits where TAPS bit is 1.
- DIV_SLOW, 50000000, CLOCK_50 cycles per tick when speed=0.
- DIV_FAST, 25000000, CLOCK_50 cycles per tick when speed=1; must be < DIV_SLOW.
- MOLE_LIFE, 3, ticks a mole stays up; must be >= 1.
- MAX_UP, 2, maximum simultaneously lit holes; must be 1..NUM_HOLES.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; seeds and begins the game from IDLE.
- stop  in  1  level; returns to IDLE from any non-IDLE state.
- pause  in  1  level; RUN<->PAUSED.
- speed  in  1  0 = DIV_SLOW, 1 = DIV_FAST.
- hit  in  NUM_HOLES  one bit per hole, player strike.
- ctrl  out  NUM_HOLES  registered mole-up flags.
- running  out  1  high in RUN.
- tick  out  1  one-cycle pulse on each game tick.

Behaviour:
- Reset (async, active-high): state=IDLE; seed counter, lfsr, div counter, all life counters=0; ctrl=0, running=0, tick=0.
- Seed counter:
  - LFSR_W bits; +1 every cycle in all states; wraps at all-ones to 0.
- FSM states: IDLE, LOAD, RUN, PAUSED.
  - IDLE: ctrl held 0. start=1 -> LOAD.
  - LOAD (exactly 1 cycle): lfsr <= seed counter value; if that value is 0, lfsr <= 1 (lockup avoidance). Clear div counter. -> RUN.
  - RUN: running=1. pause=1 -> PAUSED. stop=1 -> IDLE.
  - PAUSED: div counter, lfsr, life counters and ctrl frozen; hit ignored. pause=0 -> RUN. stop=1 -> IDLE.
  - Priority in every state: stop > pause > start.
  - Entering IDLE clears ctrl and life counters on the same edge.
- Tick divider (RUN only):
  - DIV = speed ? DIV_FAST : DIV_SLOW.
  - div counts 0..DIV-1; tick=1 for the cycle where div==DIV-1, and div wraps to 0 on that edge.
  - Speed changed mid-count with div >= new DIV-1: tick fires that cycle and div wraps.
- LFSR step, on tick only:
  - fb = ^(lfsr & TAPS); lfsr <= {fb, lfsr[LFSR_W-1:1]}.
  - Spawn decision uses the pre-step lfsr value.
- Spawn, on tick:
  - idx = lfsr[log2(NUM_HOLES)-1:0]; want = lfsr[LFSR_W-1].
  - Spawn iff want=1, ctrl[idx]=0, hit[idx]=0, and popcount(ctrl) < MAX_UP. popcount uses current registered ctrl, before this edge's expiries and hits.
  - On spawn: ctrl[idx] <= 1, life[idx] <= MOLE_LIFE.
- Expiry, on tick: every lit hole not spawned this tick has life decremented; a decrement from 1 clears ctrl.
- Hit (RUN, any cycle):
  - hit[i]=1 with ctrl[i]=1: clear ctrl[i] and life[i] on the next edge.
  - hit on an unlit hole: no effect.
  - Hit and expiry in the same cycle: cleared once, no error.
  - Multiple simultaneous hits are all honoured.
- Width rules:
  - life counters are clog2(MOLE_LIFE+1) bits.
  - div is clog2(DIV_SLOW) bits.
  - popcount is clog2(NUM_HOLES+1) bits.
- Mid-operation reset: asynchronous, immediate return to all reset values, regardless of state.

Decomposition:
- Shared package mole_pkg:
  - FSM state enum (IDLE/LOAD/RUN/PAUSED).
  - clog2 helper function.
  - Default TAPS constant.
- One sub-module, mole_lfsr (seed load with zero guard, step enable, TAPS parameter), reusable by other random sources in the game.
- Divider, life counters and FSM stay in the top.

Test Plan (bench params DIV_SLOW=4, DIV_FAST=2, MOLE_LIFE=3, MAX_UP=2):
1. Reset, hold start=0 for 9 cycles, then start=1 -> LOAD loads lfsr=seed value sampled that cycle (bench model tracks counter); first tick 4 cycles after entering RUN; running=1.
2. Seed-zero case: release reset and assert start on the first edge, so the counter is 0 at LOAD -> lfsr=16'h0001; after 16 ticks lfsr matches the bench model sequence with taps 0,2,3,5.
3. Force lfsr=16'h8003 via start timing -> on the next tick ctrl[3]=1; three ticks later ctrl[3]=0 with no hit.
4. Two moles lit and a tick with want=1 on a third hole -> no spawn; ctrl popcount stays 2.
5. Lit hole i, pulse hit[i] for 1 cycle -> ctrl[i]=0 next edge. hit on an unlit hole -> no change. hit[idx] coincident with spawn tick -> no spawn.
6. pause=1 for 20 cycles -> no tick, ctrl frozen. speed 0->1 with div=3 -> tick same cycle. stop=1 -> ctrl=0, IDLE. Async reset mid-RUN -> all outputs 0 before the next edge.
